// File: rtl/draw_sequencer_if.sv
// Bundle between draw_sequencer and its environment: object table read port,
// rectangle draw unit handshake/pixel stream, and VGA adapter write port.
interface draw_sequencer_if;
  logic [3:0] obj_idx;
  logic [7:0] obj_x;
  logic [6:0] obj_y;
  logic [4:0] obj_w;
  logic [4:0] obj_h;
  logic [2:0] obj_c;
  logic       obj_valid;

  logic [7:0] d_x;
  logic [6:0] d_y;
  logic [4:0] d_w;
  logic [4:0] d_h;
  logic [2:0] d_c;
  logic       d_enable;
  logic       d_done;
  logic [7:0] d_px;
  logic [6:0] d_py;
  logic [2:0] d_pc;

  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_c;
  logic       vga_plot;

  modport master (
    output obj_idx, d_x, d_y, d_w, d_h, d_c, d_enable,
           vga_x, vga_y, vga_c, vga_plot,
    input  obj_x, obj_y, obj_w, obj_h, obj_c, obj_valid,
           d_done, d_px, d_py, d_pc
  );

  modport slave (
    input  obj_idx, d_x, d_y, d_w, d_h, d_c, d_enable,
           vga_x, vga_y, vga_c, vga_plot,
    output obj_x, obj_y, obj_w, obj_h, obj_c, obj_valid,
           d_done, d_px, d_py, d_pc
  );
endinterface

// File: rtl/draw_sequencer.sv
// Frame initiator: optional full-screen clear, then walks the object table driving
// the rectangle draw unit and forwarding its pixels. Clear phase built when DRAW_SEQ_CLEAR_EN is defined.
module draw_sequencer #(
  parameter int unsigned NUM_OBJ      = 8,
  parameter logic [2:0]  CLEAR_COLOUR = 3'b000,
  parameter int unsigned WDOG_MAX     = 1023
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  draw_sequencer_if.master bus,
  output logic             busy,
  output logic             frame_done,
  output logic             err
);
  localparam int         WDW      = $clog2(WDOG_MAX + 1);
  localparam logic [3:0] LAST_IDX = 4'(NUM_OBJ - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_FETCH, S_LOAD, S_DRAW, S_NEXT, S_FDONE
  } state_e;

  state_e         state_q, state_d;
  logic [3:0]     obj_idx_q, obj_idx_d;
  logic [7:0]     d_x_q, d_x_d;
  logic [6:0]     d_y_q, d_y_d;
  logic [4:0]     d_w_q, d_w_d;
  logic [4:0]     d_h_q, d_h_d;
  logic [2:0]     d_c_q, d_c_d;
  logic [WDW-1:0] wdog_q, wdog_d;
  logic           err_q, err_d;
`ifdef DRAW_SEQ_CLEAR_EN
  logic [7:0]     cx_q, cx_d;
  logic [6:0]     cy_q, cy_d;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      obj_idx_q <= '0;
      d_x_q     <= '0;
      d_y_q     <= '0;
      d_w_q     <= '0;
      d_h_q     <= '0;
      d_c_q     <= '0;
      wdog_q    <= '0;
      err_q     <= 1'b0;
`ifdef DRAW_SEQ_CLEAR_EN
      cx_q      <= '0;
      cy_q      <= '0;
`endif
    end else begin
      state_q   <= state_d;
      obj_idx_q <= obj_idx_d;
      d_x_q     <= d_x_d;
      d_y_q     <= d_y_d;
      d_w_q     <= d_w_d;
      d_h_q     <= d_h_d;
      d_c_q     <= d_c_d;
      wdog_q    <= wdog_d;
      err_q     <= err_d;
`ifdef DRAW_SEQ_CLEAR_EN
      cx_q      <= cx_d;
      cy_q      <= cy_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    obj_idx_d    = obj_idx_q;
    d_x_d        = d_x_q;
    d_y_d        = d_y_q;
    d_w_d        = d_w_q;
    d_h_d        = d_h_q;
    d_c_d        = d_c_q;
    wdog_d       = wdog_q;
    err_d        = err_q;
`ifdef DRAW_SEQ_CLEAR_EN
    cx_d         = cx_q;
    cy_d         = cy_q;
`endif
    bus.d_enable = 1'b0;
    bus.vga_x    = '0;
    bus.vga_y    = '0;
    bus.vga_c    = '0;
    bus.vga_plot = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          err_d     = 1'b0;
          obj_idx_d = '0;
`ifdef DRAW_SEQ_CLEAR_EN
          state_d   = S_CLEAR;
`else
          state_d   = S_FETCH;
`endif
        end
      end
`ifdef DRAW_SEQ_CLEAR_EN
      S_CLEAR: begin
        bus.vga_x    = cx_q;
        bus.vga_y    = cy_q;
        bus.vga_c    = CLEAR_COLOUR;
        bus.vga_plot = 1'b1;
        if (cx_q == 8'd159) begin
          cx_d = '0;
          if (cy_q == 7'd119) begin
            cy_d    = '0;
            state_d = S_FETCH;
          end else begin
            cy_d = cy_q + 7'd1;
          end
        end else begin
          cx_d = cx_q + 8'd1;
        end
      end
`endif
      S_FETCH: begin
        d_x_d = bus.obj_x;
        d_y_d = bus.obj_y;
        d_w_d = bus.obj_w;
        d_h_d = bus.obj_h;
        d_c_d = bus.obj_c;
        // A zero-sized rectangle would never complete in the draw unit.
        if (!bus.obj_valid || bus.obj_w == '0 || bus.obj_h == '0)
          state_d = S_NEXT;
        else
          state_d = S_LOAD;
      end
      S_LOAD: begin
        wdog_d  = '0;
        state_d = S_DRAW;
      end
      S_DRAW: begin
        bus.d_enable = 1'b1;
        bus.vga_x    = bus.d_px;
        bus.vga_y    = bus.d_py;
        bus.vga_c    = bus.d_pc;
        bus.vga_plot = ~bus.d_done;
        if (bus.d_done) begin
          wdog_d  = '0;
          state_d = S_NEXT;
        end else if (wdog_q == WDW'(WDOG_MAX - 1)) begin
          err_d   = 1'b1;
          wdog_d  = '0;
          state_d = S_NEXT;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      S_NEXT: begin
        if (obj_idx_q == LAST_IDX) begin
          state_d = S_FDONE;
        end else begin
          obj_idx_d = obj_idx_q + 4'd1;
          state_d   = S_FETCH;
        end
      end
      S_FDONE: begin
        obj_idx_d = '0;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.obj_idx = obj_idx_q;
  assign bus.d_x     = d_x_q;
  assign bus.d_y     = d_y_q;
  assign bus.d_w     = d_w_q;
  assign bus.d_h     = d_h_q;
  assign bus.d_c     = d_c_q;
  assign busy        = (state_q != S_IDLE);
  assign frame_done  = (state_q == S_FDONE);
  assign err         = err_q;
endmodule

// File: tb/tb_draw_sequencer.sv
// Bench for draw_sequencer: object table and row-major rectangle responder, table-driven
// single-object frames, randomized tables against a pixel-list model, and corner sequences.
module tb_draw_sequencer;
  localparam int NOBJ = 8;
  localparam int WDOG = 1023;
`ifdef DRAW_SEQ_CLEAR_EN
  localparam int CLR_N  = 19200;
  localparam int N_TAB  = 1;
  localparam int N_RAND = 0;
`else
  localparam int CLR_N  = 0;
  localparam int N_TAB  = 7;
  localparam int N_RAND = 12;
`endif
  localparam int BUDGET = CLR_N + 8000;

  typedef struct {int x; int y; int c; int t;} pix_t;
  typedef struct {
    int x; int y; int w; int h; int c; int v;
    int n_plot; int n_en; int n_busy;
    int fx; int fy; int lx; int ly;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic busy, frame_done, err;
  always #5 clk = ~clk;

  draw_sequencer_if bus();

  draw_sequencer #(.NUM_OBJ(NOBJ), .CLEAR_COLOUR(3'b000), .WDOG_MAX(WDOG)) dut (
    .clk(clk), .reset(reset), .start(start), .bus(bus),
    .busy(busy), .frame_done(frame_done), .err(err)
  );

  // Object table
  int tx[16], ty[16], tw[16], th[16], tc[16], tv[16];
  int hang_idx = -1;
  always_comb begin
    bus.obj_x     = 8'(tx[bus.obj_idx]);
    bus.obj_y     = 7'(ty[bus.obj_idx]);
    bus.obj_w     = 5'(tw[bus.obj_idx]);
    bus.obj_h     = 5'(th[bus.obj_idx]);
    bus.obj_c     = 3'(tc[bus.obj_idx]);
    bus.obj_valid = (tv[bus.obj_idx] != 0);
  end

  // Behavioural draw unit: one pixel per enabled cycle, row-major, then done.
  int rcnt = 0;
  int rw;
  always_comb begin
    rw         = (bus.d_w == '0) ? 1 : int'(bus.d_w);
    bus.d_done = 1'b0;
    bus.d_px   = '0;
    bus.d_py   = '0;
    bus.d_pc   = '0;
    if (bus.d_enable) begin
      if (int'(bus.obj_idx) != hang_idx && rcnt >= int'(bus.d_w) * int'(bus.d_h)) begin
        bus.d_done = 1'b1;
      end else begin
        bus.d_px = bus.d_x + 8'(rcnt % rw);
        bus.d_py = bus.d_y + 7'(rcnt / rw);
        bus.d_pc = bus.d_c;
      end
    end
  end
  always @(posedge clk) begin
    if (!bus.d_enable) rcnt <= 0;
    else if (!bus.d_done) rcnt <= rcnt + 1;
  end

  // Monitor
  pix_t plots[$];
  int cyc = 0, n_en = 0, n_busy = 0, n_fd = 0, fd_cyc = -1, last_busy = -1;
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (bus.vga_plot) plots.push_back('{int'(bus.vga_x), int'(bus.vga_y), int'(bus.vga_c), cyc});
    if (bus.d_enable) n_en <= n_en + 1;
    if (busy) begin
      n_busy    <= n_busy + 1;
      last_busy <= cyc;
    end
    if (frame_done) begin
      n_fd   <= n_fd + 1;
      fd_cyc <= cyc;
    end
  end

  int checks = 0, failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference model: pixel list and cycle counts straight from the table.
  pix_t expq[$];
  task automatic build_model(output int nb, output int ne);
    expq.delete();
    nb = CLR_N + 1;
    ne = 0;
    for (int i = 0; i < NOBJ; i++) begin
      if (tv[i] != 0 && tw[i] > 0 && th[i] > 0) begin
        for (int r = 0; r < th[i]; r++)
          for (int q = 0; q < tw[i]; q++)
            expq.push_back('{(tx[i] + q) % 256, (ty[i] + r) % 128, tc[i], 0});
        nb += 3 + tw[i] * th[i] + 1;
        ne += tw[i] * th[i] + 1;
      end else begin
        nb += 2;
      end
    end
  endtask

  task automatic cmp_plots(input string nm, input int p0);
    int n, bad, lim;
    n   = plots.size() - p0 - CLR_N;
    bad = -1;
    chk({nm, "_nplot"}, n, expq.size());
    lim = (n < expq.size()) ? n : expq.size();
    for (int k = 0; k < lim; k++) begin
      pix_t a;
      a = plots[p0 + CLR_N + k];
      if (a.x != expq[k].x || a.y != expq[k].y || a.c != expq[k].c) begin
        bad = k;
        break;
      end
    end
    checks++;
    if (bad >= 0) begin
      failures++;
      $display("FAIL %s_pix: idx %0d got (%0d,%0d,%0d) expected (%0d,%0d,%0d)", nm, bad,
               plots[p0 + CLR_N + bad].x, plots[p0 + CLR_N + bad].y, plots[p0 + CLR_N + bad].c,
               expq[bad].x, expq[bad].y, expq[bad].c);
    end
  endtask

`ifdef DRAW_SEQ_CLEAR_EN
  task automatic check_clear(input string nm, input int p0, input int s0);
    int bad;
    bad = -1;
    for (int k = 0; k < CLR_N; k++) begin
      if (p0 + k >= plots.size()) begin bad = k; break; end
      if (plots[p0 + k].x != k % 160 || plots[p0 + k].y != k / 160 ||
          plots[p0 + k].c != 0 || plots[p0 + k].t != s0 + k) begin
        bad = k;
        break;
      end
    end
    checks++;
    if (bad >= 0) begin
      failures++;
      $display("FAIL %s_clear: raster broken at pixel %0d (expected (%0d,%0d) c=0 cycle %0d)",
               nm, bad, bad % 160, bad / 160, s0 + bad);
    end
  endtask
`endif

  task automatic clear_table();
    for (int i = 0; i < 16; i++) begin
      tx[i] = 0; ty[i] = 0; tw[i] = 0; th[i] = 0; tc[i] = 0; tv[i] = 0;
    end
  endtask

  // Pulse start, optionally pulse it again at loop iteration 'poke', wait for IDLE.
  task automatic run_frame(input string nm, input int poke,
                           output int b, output int e, output int f, output int p0);
    int nb0, ne0, nf0, s0;
    bit ok;
    ok = 0;
    @(negedge clk);
    start = 1'b1;
    #1;
    nb0 = n_busy; ne0 = n_en; nf0 = n_fd; p0 = plots.size(); s0 = cyc;
    for (int i = 0; i < BUDGET; i++) begin
      @(negedge clk);
      start = (i == poke);
      if (!busy) begin ok = 1; break; end
    end
    start = 1'b0;
    chk({nm, "_terminates"}, ok, 1);
    #1;
    b = n_busy - nb0; e = n_en - ne0; f = n_fd - nf0;
    chk({nm, "_fd_last_busy_cycle"}, fd_cyc, last_busy);
`ifdef DRAW_SEQ_CLEAR_EN
    check_clear(nm, p0, s0);
`endif
  endtask

  vec_t vt[7];

  initial begin
    int b, e, f, p0, eb, ee;
    bit ok;
    reset = 1'b0;
    start = 1'b0;
    clear_table();
    vt[0] = '{10, 20, 3, 2, 5, 1,   6,   7,  25,  10,  20,  12,  21};
    vt[1] = '{ 0,  0, 1, 1, 7, 1,   1,   2,  20,   0,   0,   0,   0};
    vt[2] = '{30, 40, 4, 4, 6, 0,   0,   0,  17,   0,   0,   0,   0};
    vt[3] = '{30, 40, 0, 4, 6, 1,   0,   0,  17,   0,   0,   0,   0};
    vt[4] = '{30, 40, 4, 0, 6, 1,   0,   0,  17,   0,   0,   0,   0};
    vt[5] = '{100, 80, 31, 31, 2, 1, 961, 962, 980, 100, 80, 130, 110};
    vt[6] = '{158, 119, 2, 1, 1, 1,  2,   3,  21, 158, 119, 159, 119};

    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_err", err, 0);
    chk("rst_obj_idx", bus.obj_idx, 0);
    chk("rst_dfields", {bus.d_x, bus.d_y, bus.d_w, bus.d_h, bus.d_c, bus.d_enable}, 0);
    chk("rst_vga", {bus.vga_x, bus.vga_y, bus.vga_c, bus.vga_plot}, 0);
    @(negedge clk);
    reset = 1'b1;

    // Single-entry frames from the vector table
    for (int i = 0; i < N_TAB; i++) begin
      string nm;
      nm = $sformatf("tab%0d", i);
      clear_table();
      tx[0] = vt[i].x; ty[0] = vt[i].y; tw[0] = vt[i].w;
      th[0] = vt[i].h; tc[0] = vt[i].c; tv[0] = vt[i].v;
      run_frame(nm, -1, b, e, f, p0);
      chk({nm, "_busy_cycles"}, b, vt[i].n_busy + CLR_N);
      chk({nm, "_en_cycles"}, e, vt[i].n_en);
      chk({nm, "_nplot"}, plots.size() - p0 - CLR_N, vt[i].n_plot);
      chk({nm, "_frame_done"}, f, 1);
      chk({nm, "_err"}, err, 0);
      if (vt[i].n_plot > 0 && plots.size() - p0 - CLR_N == vt[i].n_plot) begin
        chk({nm, "_first"}, {16'(plots[p0 + CLR_N].x), 8'(plots[p0 + CLR_N].y),
                             8'(plots[p0 + CLR_N].c)}, {16'(vt[i].fx), 8'(vt[i].fy), 8'(vt[i].c)});
        chk({nm, "_last"}, {16'(plots[plots.size() - 1].x), 16'(plots[plots.size() - 1].y)},
                           {16'(vt[i].lx), 16'(vt[i].ly)});
      end
    end

    // Randomized tables against the model
    for (int n = 0; n < N_RAND; n++) begin
      string nm;
      nm = $sformatf("rnd%0d", n);
      clear_table();
      for (int i = 0; i < NOBJ; i++) begin
        tv[i] = ($urandom_range(0, 9) < 7) ? 1 : 0;
        tw[i] = $urandom_range(0, 6);
        th[i] = $urandom_range(0, 6);
        tx[i] = $urandom_range(0, 150);
        ty[i] = $urandom_range(0, 110);
        tc[i] = $urandom_range(0, 7);
      end
      build_model(eb, ee);
      run_frame(nm, -1, b, e, f, p0);
      chk({nm, "_busy_cycles"}, b, eb);
      chk({nm, "_en_cycles"}, e, ee);
      chk({nm, "_frame_done"}, f, 1);
      chk({nm, "_err"}, err, 0);
      cmp_plots(nm, p0);
    end

    // Watchdog: entry 0 never completes, entry 1 must still be drawn
    clear_table();
    tx[0] = 40; ty[0] = 50; tw[0] = 2; th[0] = 2; tc[0] = 4; tv[0] = 1;
    tx[1] = 5;  ty[1] = 5;  tw[1] = 1; th[1] = 1; tc[1] = 6; tv[1] = 1;
    hang_idx = 0;
    run_frame("wdog", -1, b, e, f, p0);
    chk("wdog_err", err, 1);
    chk("wdog_frame_done", f, 1);
    chk("wdog_en_cycles", e, WDOG + 2);
    chk("wdog_busy_cycles", b, CLR_N + 3 + WDOG + 5 + 2 * (NOBJ - 2) + 1);
    chk("wdog_nplot", plots.size() - p0 - CLR_N, WDOG + 1);
    chk("wdog_last_pix", {16'(plots[plots.size() - 1].x), 8'(plots[plots.size() - 1].y),
                          8'(plots[plots.size() - 1].c)}, {16'd5, 8'd5, 8'd6});
    repeat (3) @(negedge clk);
    chk("wdog_err_sticky", err, 1);

    // Next start clears err; then reset mid-DRAW aborts the frame
    hang_idx = -1;
    clear_table();
    tx[0] = 10; ty[0] = 20; tw[0] = 3; th[0] = 2; tc[0] = 5; tv[0] = 1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("errclr_err", err, 0);
    chk("errclr_busy", busy, 1);
    ok = 0;
    for (int i = 0; i < BUDGET; i++) begin
      if (bus.d_enable) begin ok = 1; break; end
      @(negedge clk);
    end
    chk("rstmid_reach_draw", ok, 1);
    @(negedge clk);
    #1;
    f = n_fd;
    reset = 1'b0;
    #1;
    chk("rstmid_busy", busy, 0);
    chk("rstmid_enable", bus.d_enable, 0);
    chk("rstmid_plot", bus.vga_plot, 0);
    chk("rstmid_obj_idx", bus.obj_idx, 0);
    chk("rstmid_frame_done", frame_done, 0);
    chk("rstmid_dfields", {bus.d_x, bus.d_y, bus.d_w, bus.d_h, bus.d_c}, 0);
    repeat (3) @(negedge clk);
    #1;
    chk("rstmid_no_fd", n_fd - f, 0);
    chk("rstmid_idle", busy, 0);
    @(negedge clk);
    reset = 1'b1;

`ifndef DRAW_SEQ_CLEAR_EN
    // Start pulsed during DRAW must be ignored
    run_frame("poke", CLR_N + 3, b, e, f, p0);
    chk("poke_busy_cycles", b, CLR_N + 25);
    chk("poke_frame_done", f, 1);
    chk("poke_nplot", plots.size() - p0 - CLR_N, 6);
    f = n_fd;
    repeat (5) @(negedge clk);
    #1;
    chk("poke_no_restart", {busy, 8'(n_fd - f)}, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #(2ms);
    $display("FAIL global_timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end
endmodule
